seq_divider32: RTL and testbench

- Sequential unsigned 32/32 restoring divider.
- Inverse companion to the team's combinational 32-bit adder/subtractor datapath; reuses one subtract per cycle instead of a wide array.
- Used by the smart-home controller for averaging, scaling and rate computations: sensor sum / sample count, energy / time.
- Operands are accepted with a start/busy/done handshake; quotient and remainder are held until the next operation completes.

---
 rtl/seq_divider32_pkg.sv | 14 +
 rtl/seq_divider32_step.sv | 23 ++
 rtl/seq_divider32.sv | 124 ++++++++++++
 tb/tb_seq_divider32.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider32_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider32_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor and keep the difference only when it did not borrow.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   next_r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {r_i[WIDTH-1:0], q_msb_i};
    trial    = shifted - {1'b0, d_i};
    q_bit_o  = ~trial[WIDTH];
    next_r_o = q_bit_o ? trial : shifted;
  end

endmodule

// File: rtl/seq_divider32.sv
// Sequential unsigned divider: one trial subtract per cycle, WIDTH cycles per
// result, divide-by-zero resolved in a single cycle.
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       dbg_state
);

  // Handshake: start is taken on a rising edge only while in IDLE or DONE;
  // busy is high for every RUN cycle, done is a one-cycle pulse marking new
  // results, and start seen during RUN is dropped without sampling operands.

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_r;
  logic             step_bit;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r_i      (r_q),
    .q_msb_i  (q_q[WIDTH-1]),
    .d_i      (d_q),
    .next_r_o (step_r),
    .q_bit_o  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (dz_q) begin
          // Q still holds the untouched dividend here.
          quot_d  = DIV_ZERO_QUOT;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = step_r;
          q_d   = {q_q[WIDTH-2:0], step_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_d  = {q_q[WIDTH-2:0], step_bit};
            rem_d   = step_r[WIDTH-1:0];
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: an arithmetic reference model predicts
// when each result appears and what it is, checked on every cycle.
module tb_seq_divider32;
  import seq_divider32_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  div_state_e   dbg_state;

  int tests_run = 0;
  int fails = 0;

  seq_divider32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation yields a/b and a%b (or the
  // divide-by-zero pair) a fixed latency after the accepting edge.
  typedef struct {
    int           due;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t         pend[$];
  int           cyc = 0;
  int           free_cyc = 0;
  int           done_seen = 0;
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         held_dz = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    logic exp_done, exp_busy;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      free_cyc = 0;
      held_q   = '0;
      held_r   = '0;
      held_dz  = 1'b0;
    end else if (start && cyc >= free_cyc) begin
      if (divisor == 0) begin
        e.due = cyc + 1;
        e.q   = '1;
        e.r   = dividend;
        e.dz  = 1'b1;
      end else begin
        e.due = cyc + W;
        e.q   = dividend / divisor;
        e.r   = dividend % divisor;
        e.dz  = 1'b0;
      end
      free_cyc = e.due + 1;
      pend.push_back(e);
    end
    #1;
    exp_done = (pend.size() > 0) && (pend[0].due == cyc);
    exp_busy = (pend.size() > 0) && (cyc < pend[0].due);
    chk("done", {31'b0, done}, {31'b0, exp_done});
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    if (exp_done) begin
      held_q  = pend[0].q;
      held_r  = pend[0].r;
      held_dz = pend[0].dz;
      void'(pend.pop_front());
    end
    if (done) done_seen++;
    chk("quotient", quotient, held_q);
    chk("remainder", remainder, held_r);
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, held_dz});
  end

  // Waits for done, counting busy cycles seen on the way; bounded.
  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int busy_cnt);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_cnt);
  endtask

  task automatic chk_result(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edz);
    chk({name, "_q"}, quotient, eq);
    chk({name, "_r"}, remainder, er);
    chk({name, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
  endtask

  initial begin
    int bc;
    int gap;
    int extra;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, bc);
    chk_result("t100_7", 32'd14, 32'd2, 1'b0);
    chk("t100_7_busy_cycles", bc, 32'd32);

    run_op(32'hFFFF_FFFF, 32'h8000_0000, bc);
    chk_result("tmax_msb", 32'd1, 32'h7FFF_FFFF, 1'b0);

    run_op(32'h1234_5678, 32'd0, bc);
    chk_result("tdiv0", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    chk("tdiv0_busy_cycles", bc, 32'd1);
    run_op(32'd9, 32'd3, bc);
    chk_result("t9_3", 32'd3, 32'd0, 1'b0);

    run_op(32'hCAFE_F00D, 32'd1, bc);
    chk_result("tdiv1", 32'hCAFE_F00D, 32'd0, 1'b0);

    // Start pulse with new operands in the middle of a run must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd55; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    extra = done_seen;
    wait_done(bc);
    chk_result("tignore", 32'd100, 32'd0, 1'b0);
    repeat (40) @(negedge clk);
    chk("tignore_one_done", done_seen - extra, 32'd1);

    // Asynchronous reset 15 cycles into a run clears everything at once.
    @(negedge clk);
    start = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_quot", quotient, 32'd0);
    chk("arst_rem", remainder, 32'd0);
    chk("arst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hDEAD_BEEF, 32'd3, bc);
    chk_result("tdeadbeef", 32'h4A39_EA4F, 32'd2, 1'b0);

    // Start held high: back-to-back results 33 cycles apart.
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    wait_done(bc);
    chk_result("tb2b_first", 32'd10, 32'd0, 1'b0);
    dividend = 32'd7; divisor = 32'd9;
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      gap++;
      if (done) break;
    end
    start = 1'b0;
    chk("tb2b_gap", gap, 32'd33);
    chk_result("tb2b_second", 32'd0, 32'd7, 1'b0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
